ap_ctrl_sequencer: RTL and testbench

Drives the ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue) of one HLS-generated kernel instance. It issues a programmed number of transactions back-to-back and allows up to MAX_OUTSTANDING pipelined starts ahead of their dones. It gates completion on a downstream sink and reports progress counters plus a one-cycle finish pulse that simulation monitors and the testbench use to end a run.

---
 rtl/ap_ctrl_seq_pkg.sv | 26 ++
 rtl/txn_credit_counter.sv | 42 ++++
 rtl/ap_ctrl_sequencer.sv | 144 ++++++++++++++
 tb/tb_ap_ctrl_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_seq_pkg.sv
// ap_ctrl_seq_pkg: shared types, default widths and helpers
// for the ap_ctrl_chain sequencer and its credit counter.
package ap_ctrl_seq_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int MAX_OUT_DEF = 4;
  localparam int CYC_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  // Saturating +1 for a counter of width w (w <= 64).
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/txn_credit_counter.sv
// txn_credit_counter: outstanding-transaction up/down counter.
// Ports: clock, reset (async low), inc, dec -> at_limit, is_zero, next_zero.
module txn_credit_counter #(
  parameter int CNT_W           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic at_limit,
  output logic is_zero,
  output logic next_zero
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      inc && !dec: cnt_d = cnt_q + ONE;
      dec && !inc: cnt_d = cnt_q - ONE;
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Limit and zero-next look at the post-accept count so
  // the start lookahead needs no bubble.
  assign at_limit  = (cnt_d >= LIMIT);
  assign is_zero   = (cnt_q == '0);
  assign next_zero = (cnt_d == '0);

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: drives ap_ctrl_chain handshakes of one HLS kernel.
// Ports: cmd_start/abort + cfg_num_txn in; ap_* handshake; busy/finish/counters/err out.
module ap_ctrl_sequencer
  import ap_ctrl_seq_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter int CYC_W           = CYC_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             sink_ready,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] started_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             err_spurious_done
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             ap_start_q, ap_start_d;
  logic             err_q, err_d;

  logic             start_acc;
  logic             done_acc;
  logic             spur;
  logic             out_lim;
  logic             out_zero;
  logic             out_nzero;
  logic [CNT_W-1:0] started_nx;
  logic [CNT_W-1:0] done_nx;

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign ap_continue = busy & sink_ready;
  assign start_acc   = ap_start_q & ap_ready;
  assign done_acc    = ap_done & ap_continue & ~out_zero;
  // With nothing in flight any done is unexpected: while busy only
  // when it would be accepted, while not busy whenever asserted.
  assign spur        = ap_done & out_zero & (ap_continue | ~busy);
  assign started_nx  = started_q + {{(CNT_W-1){1'b0}}, start_acc};
  assign done_nx     = done_q + {{(CNT_W-1){1'b0}}, done_acc};

  txn_credit_counter #(
    .CNT_W          (CNT_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clock    (clock),
    .reset    (reset),
    .inc      (start_acc),
    .dec      (done_acc),
    .at_limit (out_lim),
    .is_zero  (out_zero),
    .next_zero(out_nzero)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    started_d  = started_q;
    done_d     = done_q;
    cyc_d      = cyc_q;
    ap_start_d = ap_start_q;
    err_d      = err_q | spur;
    if (busy) begin
      started_d = started_nx;
      done_d    = done_nx;
      cyc_d     = CYC_W'(sat_inc(64'(cyc_q), CYC_W));
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          num_d     = cfg_num_txn;
          started_d = '0;
          done_d    = '0;
          cyc_d     = '0;
          err_d     = 1'b0;
          if (cfg_num_txn != '0) begin
            state_d    = RUN;
            ap_start_d = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        ap_start_d = (ap_start_q & ~ap_ready)
                   | ((started_nx < num_q) & ~out_lim);
        if (done_nx == num_q) begin
          state_d    = FIN;
          ap_start_d = 1'b0;
        end else if (cmd_abort) begin
          state_d    = DRAIN;
          ap_start_d = ap_start_q & ~ap_ready;
        end
      end
      DRAIN: begin
        ap_start_d = ap_start_q & ~ap_ready;
        if (out_nzero && !ap_start_d) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      started_q  <= '0;
      done_q     <= '0;
      cyc_q      <= '0;
      ap_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      started_q  <= started_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      ap_start_q <= ap_start_d;
      err_q      <= err_d;
    end
  end

  assign ap_start          = ap_start_q;
  assign finish            = (state_q == FIN);
  assign started_cnt       = started_q;
  assign done_cnt          = done_q;
  assign cycle_cnt         = cyc_q;
  assign err_spurious_done = err_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb_ap_ctrl_sequencer: self-checking bench with a kernel model
// and a finish scoreboard for ap_ctrl_sequencer.
module tb_ap_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cfg_num_txn;
  logic        cmd_start;
  logic        cmd_abort;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_continue;
  logic        sink_ready;
  logic        busy;
  logic        finish;
  logic [15:0] started_cnt;
  logic [15:0] done_cnt;
  logic [31:0] cycle_cnt;
  logic        err_spurious_done;

  ap_ctrl_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_num_txn      (cfg_num_txn),
    .cmd_start        (cmd_start),
    .cmd_abort        (cmd_abort),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ap_continue      (ap_continue),
    .sink_ready       (sink_ready),
    .busy             (busy),
    .finish           (finish),
    .started_cnt      (started_cnt),
    .done_cnt         (done_cnt),
    .cycle_cnt        (cycle_cnt),
    .err_spurious_done(err_spurious_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int dn;
    bit err;
    bit lat;
    int s_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   fin_seen = 0;

  int   cyc = 0;
  int   lat = 5;
  int   done_budget = 1 << 30;
  bit   force_done = 1'b0;
  int   last_d = 0;
  int   pend[$];

  // Kernel model: returns each accepted start as a done after lat cycles.
  always @(posedge clock) begin
    bit sacc;
    bit dacc;
    cyc  = cyc + 1;
    sacc = ap_start && ap_ready;
    dacc = ap_done && ap_continue;
    #1;
    if (reset !== 1'b1) begin
      pend.delete();
      ap_done = 1'b0;
    end else begin
      if (dacc && pend.size() > 0) begin
        void'(pend.pop_front());
        last_d = cyc;
        if (done_budget > 0) done_budget--;
      end
      if (sacc) pend.push_back(cyc + lat);
      ap_done = force_done ||
        (done_budget > 0 && pend.size() > 0 && pend[0] <= cyc);
    end
  end

  // Finish scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && finish === 1'b1) begin
      fin_seen++;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL finish_unexpected: finish at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (started_cnt !== 16'(e.st) || done_cnt !== 16'(e.dn) ||
            err_spurious_done !== e.err || ap_start !== 1'b0 ||
            busy !== 1'b0 ||
            (e.lat && (cyc !== last_d ||
                       cycle_cnt !== 32'(last_d - e.s_edge))))
          $display("FAIL finish_result: st=%0d dn=%0d err=%b cyc=%0d ccnt=%0d want st=%0d dn=%0d err=%b cyc=%0d ccnt=%0d",
                   started_cnt, done_cnt, err_spurious_done, cyc, cycle_cnt,
                   e.st, e.dn, e.err, last_d, last_d - e.s_edge);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int n, input bit push,
                           input bit lchk, input int st, input int dn);
    exp_t e;
    cfg_num_txn = 16'(n);
    cmd_start   = 1'b1;
    if (push) begin
      e.st = st; e.dn = dn; e.err = 1'b0;
      e.lat = lchk; e.s_edge = cyc + 1;
      exp_q.push_back(e);
    end
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_fin(input string nm, input int budget);
    int f0;
    int k;
    f0 = fin_seen;
    k  = 0;
    while (fin_seen == f0 && k < budget) begin
      tick();
      k++;
    end
    if (fin_seen == f0) begin
      n_chk++;
      $display("FAIL %s_timeout: no finish within %0d cycles", nm, budget);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_num_txn = '0; cmd_start = 1'b0; cmd_abort = 1'b0;
    ap_ready = 1'b0; sink_ready = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({ap_start, busy, finish, ap_continue, err_spurious_done} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {ap_start, busy, finish, ap_continue, err_spurious_done});
    else n_pass++;
    n_chk++;
    if ({started_cnt, done_cnt, cycle_cnt} !== 64'd0)
      $display("FAIL reset_cnts: st=%0d dn=%0d cc=%0d want 0",
               started_cnt, done_cnt, cycle_cnt);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_zero();
    start_run(0, 1'b1, 1'b0, 0, 0);
    n_chk++;
    if (finish !== 1'b1 || ap_start !== 1'b0)
      $display("FAIL zero_fin: finish=%b ap_start=%b want 1 0", finish, ap_start);
    else n_pass++;
    tick();
    n_chk++;
    if (finish !== 1'b0 || busy !== 1'b0 || ap_start !== 1'b0)
      $display("FAIL zero_after: finish=%b busy=%b ap_start=%b want 000",
               finish, busy, ap_start);
    else n_pass++;
  endtask

  task automatic test_spurious();
    force_done = 1'b1;
    repeat (2) tick();
    force_done = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (err_spurious_done !== 1'b1 || done_cnt !== 16'd0 || busy !== 1'b0)
      $display("FAIL spurious: err=%b dn=%0d busy=%b want 1 0 0",
               err_spurious_done, done_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] pat;
    ap_ready = 1'b1; sink_ready = 1'b1; lat = 5;
    start_run(3, 1'b1, 1'b1, 3, 3);
    for (int i = 0; i < 4; i++) begin
      pat[i] = ap_start;
      tick();
    end
    n_chk++;
    if (pat !== 4'b0111)
      $display("FAIL basic_start_pattern: got %b want 0111", pat);
    else n_pass++;
    wait_fin("basic", 40);
  endtask

  task automatic test_credit();
    ap_ready = 1'b1; sink_ready = 1'b1; lat = 2; done_budget = 0;
    start_run(10, 1'b1, 1'b1, 10, 10);
    repeat (12) tick();
    n_chk++;
    if (started_cnt !== 16'd4 || ap_start !== 1'b0)
      $display("FAIL credit_stall: st=%0d ap_start=%b want 4 0",
               started_cnt, ap_start);
    else n_pass++;
    for (int i = 1; i <= 2; i++) begin
      done_budget = 1;
      repeat (6) tick();
      n_chk++;
      if (started_cnt !== 16'(4 + i) || done_cnt !== 16'(i) || ap_start !== 1'b0)
        $display("FAIL credit_step%0d: st=%0d dn=%0d ap_start=%b want %0d %0d 0",
                 i, started_cnt, done_cnt, ap_start, 4 + i, i);
      else n_pass++;
    end
    done_budget = 1 << 30;
    wait_fin("credit", 80);
  endtask

  task automatic test_backpressure();
    bit ok;
    int f0;
    ap_ready = 1'b1; sink_ready = 1'b0; lat = 2;
    start_run(2, 1'b1, 1'b1, 2, 2);
    repeat (8) tick();
    ok = 1'b1;
    f0 = fin_seen;
    repeat (20) begin
      if (!(ap_done === 1'b1 && ap_continue === 1'b0 && done_cnt === 16'd0))
        ok = 1'b0;
      tick();
    end
    n_chk++;
    if (!ok || fin_seen != f0)
      $display("FAIL backpressure_hold: ok=%b fins=%0d want 1 %0d",
               ok, fin_seen, f0);
    else n_pass++;
    sink_ready = 1'b1;
    wait_fin("backpressure", 40);
  endtask

  task automatic test_abort();
    int k;
    ap_ready = 1'b1; sink_ready = 1'b1; lat = 1;
    start_run(100, 1'b1, 1'b1, 8, 8);
    k = 0;
    while (started_cnt !== 16'd7 && k < 200) begin
      tick();
      k++;
    end
    n_chk++;
    if (started_cnt !== 16'd7 || ap_start !== 1'b1)
      $display("FAIL abort_reach7: st=%0d ap_start=%b want 7 1",
               started_cnt, ap_start);
    else n_pass++;
    ap_ready = 1'b0; cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (ap_start !== 1'b1 || started_cnt !== 16'd7 || busy !== 1'b1)
      $display("FAIL abort_hold: ap_start=%b st=%0d busy=%b want 1 7 1",
               ap_start, started_cnt, busy);
    else n_pass++;
    ap_ready = 1'b1;
    tick();
    n_chk++;
    if (ap_start !== 1'b0 || started_cnt !== 16'd8)
      $display("FAIL abort_last: ap_start=%b st=%0d want 0 8",
               ap_start, started_cnt);
    else n_pass++;
    wait_fin("abort", 40);
  endtask

  task automatic test_mid_reset();
    int k;
    ap_ready = 1'b1; sink_ready = 1'b1; lat = 20;
    start_run(5, 1'b0, 1'b0, 0, 0);
    k = 0;
    while (started_cnt !== 16'd2 && k < 50) begin
      tick();
      k++;
    end
    n_chk++;
    if (started_cnt !== 16'd2 || ap_start !== 1'b1)
      $display("FAIL midrst_reach2: st=%0d ap_start=%b want 2 1",
               started_cnt, ap_start);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({ap_start, busy} !== 2'b00 || started_cnt !== 16'd0 ||
        cycle_cnt !== 32'd0)
      $display("FAIL midrst_async: ap_start=%b busy=%b st=%0d cc=%0d want 0",
               ap_start, busy, started_cnt, cycle_cnt);
    else n_pass++;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || finish !== 1'b0 || ap_start !== 1'b0)
      $display("FAIL midrst_idle: busy=%b finish=%b ap_start=%b want 000",
               busy, finish, ap_start);
    else n_pass++;
    lat = 2;
    start_run(2, 1'b1, 1'b1, 2, 2);
    wait_fin("midrst_rerun", 40);
  endtask

  initial begin
    ap_done = 1'b0;
    test_reset();
    test_zero();
    test_spurious();
    test_basic();
    test_credit();
    test_backpressure();
    test_abort();
    test_mid_reset();
    repeat (3) tick();
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_left: %0d expected finishes never seen",
               exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
